// File: rtl/dm_ctrl_pkg.sv
// Shared encodings for the data-memory access controller.
//   SZ_*    : cpu_size encodings (3 behaves as a word access)
//   state_t : loader burst FSM states
package dm_ctrl_pkg;

   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_BYTE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/dm_ctrl_if.sv
// CPU MEM-stage port and boot/debug loader port of dm_ctrl.
//   master : CPU pipeline + loader side (drives requests, sees results)
//   slave  : dm_ctrl side
interface dm_ctrl_if #(
   parameter int LEN_W = 10
);
   logic             cpu_req;
   logic             cpu_we;
   logic [1:0]       cpu_size;
   logic             cpu_sign;
   logic [31:0]      cpu_addr;
   logic [31:0]      cpu_wdata;
   logic [31:0]      cpu_pc;
   logic [31:0]      cpu_rdata;
   logic             cpu_stall;
   logic             cpu_addr_err;

   logic             ld_start;
   logic [31:0]      ld_base;
   logic [LEN_W-1:0] ld_len;
   logic             ld_zero;
   logic             ld_valid;
   logic [31:0]      ld_data;
   logic             ld_ready;
   logic             ld_busy;
   logic             ld_done;

   modport master (
      output cpu_req, cpu_we, cpu_size, cpu_sign, cpu_addr, cpu_wdata, cpu_pc,
      input  cpu_rdata, cpu_stall, cpu_addr_err,
      output ld_start, ld_base, ld_len, ld_zero, ld_valid, ld_data,
      input  ld_ready, ld_busy, ld_done
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_size, cpu_sign, cpu_addr, cpu_wdata, cpu_pc,
      output cpu_rdata, cpu_stall, cpu_addr_err,
      input  ld_start, ld_base, ld_len, ld_zero, ld_valid, ld_data,
      output ld_ready, ld_busy, ld_done
   );
endinterface

// File: rtl/dm_lane.sv
// Sub-word lane unit (combinational).
//   size, off, sign : access size, byte offset addr[1:0], sign-extend loads
//   rd              : word currently read from memory
//   wdata           : store data, sub-word data in the low bits
//   load_data       : extracted and extended load result
//   store_data      : word to write back (rd with the addressed lane replaced)
module dm_lane
   import dm_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        sign,
   input  logic [31:0] rd,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v     = rd[{off, 3'b000} +: 8];
      half_v     = off[1] ? rd[31:16] : rd[15:0];
      load_data  = rd;
      store_data = wdata;
      case (size)
         SZ_BYTE: begin
            load_data  = {{24{sign & byte_v[7]}}, byte_v};
            store_data = rd;
            store_data[{off, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            // off[0] set is a misaligned half; the top decides what to do with it
            load_data  = {{16{sign & half_v[15]}}, half_v};
            store_data = rd;
            if (off[1]) store_data[31:16] = wdata[15:0];
            else        store_data[15:0]  = wdata[15:0];
         end
         default: begin
            load_data  = rd;
            store_data = wdata;
         end
      endcase
   end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory access controller: shares one word-wide memory port between
// the CPU MEM stage and a burst/zero-fill loader, with sub-word accesses
// done as read-merge-write on the asynchronous read path.
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : CPU request/response and loader handshake
//   dm_pc/A/WD/WE   : memory pc-log, address, write data, write enable
//   dm_DMOp         : memory load op, always word
//   dm_RD           : asynchronous memory read word
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no burst; ld_start latches base/len/zero
// ST_RUN  | burst in progress, one beat per grant
// ST_DONE | one-cycle completion pulse, then back to idle
module dm_ctrl
   import dm_ctrl_pkg::*;
#(
   parameter int LEN_W      = 10,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   dm_ctrl_if.slave    bus,
   output logic [31:0] dm_pc,
   output logic [31:0] dm_A,
   output logic [31:0] dm_WD,
   output logic        dm_WE,
   output logic [2:0]  dm_DMOp,
   input  logic [31:0] dm_RD
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]    STARVE_INIT = SW'(STARVE_MAX);
   localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);

   state_t           state_q, state_d;
   logic [31:0]      base_q, base_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             zero_q, zero_d;
   // starvation timer: counts denied pending cycles down to a forced grant
   logic [SW-1:0]    starve_left_q, starve_left_d;

   logic        pending, grant, cpu_go, is_word, is_half, addr_err;
   logic [31:0] lane_load, lane_store;
   logic        unused_base;

   assign unused_base = ^bus.ld_base[1:0];

   assign pending  = (state_q == ST_RUN) & (bus.ld_valid | zero_q);
   assign grant    = ~reset & pending & (~bus.cpu_req | (starve_left_q == '0));
   assign cpu_go   = ~reset & bus.cpu_req & ~grant;
   assign is_half  = (bus.cpu_size == SZ_HALF);
   assign is_word  = ~is_half & (bus.cpu_size != SZ_BYTE);
   assign addr_err = bus.cpu_req & ((is_word & (bus.cpu_addr[1:0] != 2'b00)) |
                                    (is_half & bus.cpu_addr[0]));

   dm_lane u_lane (
      .size       (bus.cpu_size),
      .off        (bus.cpu_addr[1:0]),
      .sign       (bus.cpu_sign),
      .rd         (dm_RD),
      .wdata      (bus.cpu_wdata),
      .load_data  (lane_load),
      .store_data (lane_store)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         base_q        <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         zero_q        <= 1'b0;
         starve_left_q <= STARVE_INIT;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         zero_q        <= zero_d;
         starve_left_q <= starve_left_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      zero_d        = zero_q;
      starve_left_d = starve_left_q;
      case (state_q)
         ST_IDLE: begin
            starve_left_d = STARVE_INIT;
            if (bus.ld_start) begin
               base_d  = {bus.ld_base[31:2], 2'b00};
               len_d   = bus.ld_len;
               zero_d  = bus.ld_zero;
               cnt_d   = '0;
               state_d = (bus.ld_len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (grant) begin
               cnt_d         = cnt_q + LEN_ONE;
               starve_left_d = STARVE_INIT;
               if (cnt_q == len_q - LEN_ONE) state_d = ST_DONE;
            end else if (pending) begin
               starve_left_d = starve_left_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dm_A    = bus.cpu_addr;
      dm_WD   = lane_store;
      dm_pc   = bus.cpu_pc;
      dm_WE   = 1'b0;
      dm_DMOp = 3'd0;
      if (grant) begin
         dm_A  = base_q + (32'(cnt_q) << 2);
         dm_WD = zero_q ? 32'd0 : bus.ld_data;
         dm_pc = 32'd0;
         dm_WE = 1'b1;
      end else if (cpu_go & bus.cpu_we & ~addr_err) begin
         dm_WE = 1'b1;
      end
   end

   assign bus.cpu_rdata    = addr_err ? 32'd0 : lane_load;
   assign bus.cpu_stall    = grant & bus.cpu_req;
   assign bus.cpu_addr_err = addr_err;
   assign bus.ld_ready     = grant & ~zero_q;
   assign bus.ld_busy      = (state_q == ST_RUN);
   assign bus.ld_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_dm_ctrl.sv
module tb_dm_ctrl;

   localparam int LEN_W      = 10;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dm_ctrl_if #(.LEN_W(LEN_W)) bus ();

   logic [31:0] dm_pc, dm_A, dm_WD, dm_RD;
   logic        dm_WE;
   logic [2:0]  dm_DMOp;

   dm_ctrl #(.LEN_W(LEN_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .dm_pc   (dm_pc),
      .dm_A    (dm_A),
      .dm_WD   (dm_WD),
      .dm_WE   (dm_WE),
      .dm_DMOp (dm_DMOp),
      .dm_RD   (dm_RD)
   );

   // 256-word memory; addresses alias modulo 1 KiB
   logic [31:0] mem [0:255];
   assign dm_RD = mem[dm_A[9:2]];
   always @(posedge clk) if (dm_WE) mem[dm_A[9:2]] <= dm_WD;

   // behavioural reference
   logic [31:0] ref_mem [0:255];
   bit          m_run, m_done, m_zero;
   logic [31:0] m_base;
   int          m_len, m_idx, m_deny;

   int errors = 0;
   int checks = 0;

   logic [31:0] s_rdata, s_a;
   bit          s_we, s_done, s_busy, s_stall, s_err, s_ready;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input bit sgn);
      logic [31:0] v;
      int sh;
      if (sz == 2'd1) begin
         sh = off[1] ? 16 : 0;
         v = (w >> sh) & 32'hFFFF;
         if (sgn && v[15]) v = v | 32'hFFFF0000;
      end else if (sz == 2'd2) begin
         sh = 8 * int'(off);
         v = (w >> sh) & 32'hFF;
         if (sgn && v[7]) v = v | 32'hFFFFFF00;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] st_model(input logic [31:0] w, input logic [31:0] d,
                                            input logic [1:0] sz, input logic [1:0] off);
      int sh;
      if (sz == 2'd1) begin
         sh = off[1] ? 16 : 0;
         return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end else if (sz == 2'd2) begin
         sh = 8 * int'(off);
         return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end
      return d;
   endfunction

   // one clock: check outputs at negedge, advance the model at posedge
   task automatic step();
      bit g, st, er, we_e, is_w, go;
      logic [31:0] a_e, wd_e, pc_e, cur;
      @(negedge clk);
      is_w = (bus.cpu_size == 2'd0) || (bus.cpu_size == 2'd3);
      er   = bus.cpu_req && ((is_w && bus.cpu_addr[1:0] != 2'd0) ||
                             (bus.cpu_size == 2'd1 && bus.cpu_addr[0]));
      g    = !reset && m_run && (bus.ld_valid || m_zero) &&
             (!bus.cpu_req || m_deny == STARVE_MAX);
      st   = g && bus.cpu_req;
      go   = !reset && bus.cpu_req && !st;
      we_e = g || (go && bus.cpu_we && !er);
      cur  = ref_mem[bus.cpu_addr[9:2]];
      if (g) begin
         a_e  = m_base + 32'(m_idx * 4);
         wd_e = m_zero ? 32'd0 : bus.ld_data;
         pc_e = 32'd0;
      end else begin
         a_e  = bus.cpu_addr;
         wd_e = st_model(cur, bus.cpu_wdata, bus.cpu_size, bus.cpu_addr[1:0]);
         pc_e = bus.cpu_pc;
      end
      chk("cpu_stall", 32'(bus.cpu_stall), 32'(st));
      chk("ld_ready", 32'(bus.ld_ready), 32'(g && !m_zero));
      chk("ld_busy", 32'(bus.ld_busy), 32'(m_run));
      chk("ld_done", 32'(bus.ld_done), 32'(m_done));
      chk("addr_err", 32'(bus.cpu_addr_err), 32'(er));
      chk("dm_WE", 32'(dm_WE), 32'(we_e));
      chk("dm_DMOp", 32'(dm_DMOp), 32'd0);
      if (we_e) begin
         chk("dm_A", dm_A, a_e);
         chk("dm_WD", dm_WD, wd_e);
         chk("dm_pc", dm_pc, pc_e);
      end
      if (bus.cpu_req && !bus.cpu_we && !st)
         chk("cpu_rdata", bus.cpu_rdata,
             er ? 32'd0 : ld_model(cur, bus.cpu_size, bus.cpu_addr[1:0], bus.cpu_sign));
      s_rdata = bus.cpu_rdata;
      s_a     = dm_A;
      s_we    = dm_WE;
      s_done  = bus.ld_done;
      s_busy  = bus.ld_busy;
      s_stall = bus.cpu_stall;
      s_err   = bus.cpu_addr_err;
      s_ready = bus.ld_ready;
      @(posedge clk);
      if (reset) begin
         m_run  = 1'b0;
         m_done = 1'b0;
         m_deny = 0;
      end else begin
         if (we_e) ref_mem[a_e[9:2]] = wd_e;
         if (m_done) begin
            m_done = 1'b0;
         end else if (m_run) begin
            if (g) begin
               m_idx++;
               m_deny = 0;
               if (m_idx == m_len) begin
                  m_run  = 1'b0;
                  m_done = 1'b1;
               end
            end else if (bus.ld_valid || m_zero) begin
               m_deny++;
            end
         end else if (bus.ld_start) begin
            m_base = {bus.ld_base[31:2], 2'b00};
            m_len  = int'(bus.ld_len);
            m_zero = bus.ld_zero;
            m_idx  = 0;
            m_deny = 0;
            if (m_len == 0) m_done = 1'b1;
            else            m_run  = 1'b1;
         end
      end
      #1;
   endtask

   task automatic set_cpu(input bit req, input bit we, input logic [1:0] sz, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
      bus.cpu_req   = req;
      bus.cpu_we    = we;
      bus.cpu_size  = sz;
      bus.cpu_sign  = sgn;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      bus.cpu_pc    = $urandom;
   endtask

   task automatic set_ld(input bit start, input logic [31:0] base, input int len,
                         input bit zero, input bit valid);
      bus.ld_start = start;
      bus.ld_base  = base;
      bus.ld_len   = LEN_W'(len);
      bus.ld_zero  = zero;
      bus.ld_valid = valid;
      bus.ld_data  = $urandom;
   endtask

   initial begin
      m_run = 0; m_done = 0; m_zero = 0; m_base = 0; m_len = 0; m_idx = 0; m_deny = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
      set_cpu(1, 1, 2'd0, 0, 32'h100, 32'hDEAD0000);
      set_ld(0, 0, 0, 0, 0);
      reset = 1'b1;
      step();
      step();
      chk("rst_busy", 32'(s_busy), 32'd0);
      chk("rst_done", 32'(s_done), 32'd0);
      chk("rst_we", 32'(s_we), 32'd0);
      chk("rst_stall", 32'(s_stall), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 256; i++) begin
         set_cpu(1, 1, 2'd0, 0, 32'(i * 4), $urandom);
         step();
      end

      // sub-word stores and loads
      set_cpu(1, 1, 2'd0, 0, 32'h100, 32'h11223344); step();
      set_cpu(1, 1, 2'd2, 0, 32'h101, 32'h000000AB); step();
      set_cpu(1, 0, 2'd0, 0, 32'h100, 0); step();
      chk("sb_merge", s_rdata, 32'h1122AB44);
      set_cpu(1, 0, 2'd2, 1, 32'h101, 0); step();
      chk("lb", s_rdata, 32'hFFFFFFAB);
      set_cpu(1, 0, 2'd2, 0, 32'h101, 0); step();
      chk("lbu", s_rdata, 32'h000000AB);
      set_cpu(1, 1, 2'd1, 0, 32'h102, 32'h0000BEEF); step();
      set_cpu(1, 0, 2'd0, 0, 32'h100, 0); step();
      chk("sh_merge", s_rdata, 32'hBEEFAB44);

      // misalignment
      set_cpu(1, 0, 2'd0, 0, 32'h102, 0); step();
      chk("lw_mis_err", 32'(s_err), 32'd1);
      chk("lw_mis_rdata", s_rdata, 32'd0);
      set_cpu(1, 1, 2'd1, 0, 32'h103, 32'h1234); step();
      chk("sh_mis_err", 32'(s_err), 32'd1);
      chk("sh_mis_we", 32'(s_we), 32'd0);
      set_cpu(1, 0, 2'd0, 0, 32'h100, 0); step();
      chk("mis_unchanged", s_rdata, 32'hBEEFAB44);

      // burst with idle CPU
      set_cpu(0, 0, 2'd0, 0, 0, 0);
      set_ld(1, 32'h40, 3, 0, 1); step();
      for (int k = 0; k < 3; k++) begin
         set_ld(0, 32'h40, 3, 0, 1); step();
         chk("burst_we", 32'(s_we), 32'd1);
         chk("burst_addr", s_a, 32'(32'h40 + 4 * k));
      end
      set_ld(0, 0, 0, 0, 0); step();
      chk("burst_done", 32'(s_done), 32'd1);
      step();
      chk("burst_done_off", 32'(s_done), 32'd0);

      // starvation with CPU requesting every cycle
      set_cpu(1, 0, 2'd0, 0, 32'h200, 0);
      set_ld(1, 32'h80, 2, 1, 0); step();
      bus.ld_start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         step();
         chk("starve_stall", 32'(s_stall), 32'((c == 5) || (c == 10)));
      end
      set_cpu(1, 0, 2'd0, 0, 32'h80, 0); step();
      chk("zfill0", s_rdata, 32'd0);
      set_cpu(1, 0, 2'd0, 0, 32'h84, 0); step();
      chk("zfill1", s_rdata, 32'd0);

      // zero-length burst
      set_cpu(0, 0, 2'd0, 0, 0, 0);
      set_ld(1, 32'h10, 0, 0, 1); step();
      set_ld(0, 0, 0, 0, 1); step();
      chk("len0_done", 32'(s_done), 32'd1);
      chk("len0_we", 32'(s_we), 32'd0);
      step();
      chk("len0_done_off", 32'(s_done), 32'd0);

      // ld_start while busy is ignored
      set_ld(1, 32'h20, 2, 0, 0); step();
      set_ld(1, 32'h300, 5, 1, 0); step(); step();
      set_ld(0, 32'h300, 5, 1, 1); step();
      chk("busy_ign_a0", s_a, 32'h20);
      set_ld(0, 32'h300, 5, 1, 1); step();
      chk("busy_ign_a1", s_a, 32'h24);
      set_ld(0, 0, 0, 0, 0); step();
      chk("busy_ign_done", 32'(s_done), 32'd1);

      // reset mid-burst
      set_ld(1, 32'hC0, 3, 0, 1); step();
      set_ld(0, 32'hC0, 3, 0, 1); step();
      chk("rst_beat1", s_a, 32'hC0);
      reset = 1'b1; step();
      reset = 1'b0;
      set_ld(0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("abort_done", 32'(s_done), 32'd0);
         chk("abort_busy", 32'(s_busy), 32'd0);
      end

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [1:0]  sz;
         logic [31:0] a;
         reset = ($urandom_range(0, 399) == 0);
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            else if (sz != 2'd2) a[1:0] = 2'b00;
         end
         set_cpu(($urandom_range(0, 2) != 0), $urandom_range(0, 1), sz,
                 $urandom_range(0, 1), a, $urandom);
         set_ld(($urandom_range(0, 11) == 0), $urandom, $urandom_range(0, 6),
                ($urandom_range(0, 2) == 0), $urandom_range(0, 1));
         step();
      end
      reset = 1'b0;

      set_cpu(0, 0, 2'd0, 0, 0, 0);
      set_ld(0, 0, 0, 0, 0);
      step();
      step();
      for (int i = 0; i < 256; i++) chk("mem_final", mem[i], ref_mem[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
